// File: rtl/vertex_transform_stream_if.sv
// Vertex transform stream bus: matrix load, vertex input and
// buffered clip-space output with mesh completion pulse.
interface vertex_transform_stream_if #(
  parameter int DATAWIDTH = 24
);
  logic [3:0][3:0][DATAWIDTH-1:0] mvp;
  logic                           mvp_valid;
  logic                           mvp_ready;
  logic [2:0][DATAWIDTH-1:0]      vtx;
  logic                           vtx_last;
  logic                           vtx_valid;
  logic                           vtx_ready;
  logic [3:0][DATAWIDTH-1:0]      res;
  logic                           res_behind;
  logic                           res_last;
  logic                           res_valid;
  logic                           res_ready;
  logic                           finished;

  modport master (
    output mvp, mvp_valid, vtx, vtx_last, vtx_valid, res_ready,
    input  mvp_ready, vtx_ready, res, res_behind, res_last,
    input  res_valid, finished
  );

  modport slave (
    input  mvp, mvp_valid, vtx, vtx_last, vtx_valid, res_ready,
    output mvp_ready, vtx_ready, res, res_behind, res_last,
    output res_valid, finished
  );
endinterface

// File: rtl/vertex_transform_stream.sv
// Streaming MVP vertex transform: lane-parallel fixed-point MAC
// with a registered output FIFO absorbing downstream backpressure.
module vertex_transform_stream #(
  parameter int DATAWIDTH = 24,
  parameter int FRACBITS  = 13,
  parameter int LANES     = 2,
  parameter int OUT_DEPTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  vertex_transform_stream_if.slave  bus
);
  localparam int DW     = DATAWIDTH;
  localparam int AW2    = 2 * DW + 2;
  localparam int PASSES = 4 / LANES;
  localparam int BEATS  = 4 * PASSES;
  localparam int PW     = $clog2(OUT_DEPTH);

  localparam logic [DW-1:0] ONE = DW'(1) << FRACBITS;
  localparam logic signed [AW2-1:0] ZERO = '0;
  localparam logic signed [AW2-1:0] SMAX =
    $signed({{(AW2-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [AW2-1:0] SMIN =
    $signed({{(AW2-DW+1){1'b1}}, {(DW-1){1'b0}}});

  typedef enum logic [2:0] {
    IDLE, ACCEPT, COMPUTE, WRITE, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic [3:0][DW-1:0] vec;
    logic               behind;
    logic               last;
  } entry_t;

  state_t state, nxt;

  logic [3:0][3:0][DW-1:0] mat;
  logic [3:0][DW-1:0]      vin;
  logic [3:0][DW-1:0]      stage;
  logic                    last_r;
  logic [3:0]              cnt;
  logic [1:0]              beat;
  logic [1:0]              pass;

  logic [1:0]              row  [LANES];
  logic signed [2*DW-1:0]  prod [LANES];
  logic signed [AW2-1:0]   sum  [LANES];
  logic signed [AW2-1:0]   acc  [LANES];

  entry_t          mem [OUT_DEPTH];
  entry_t          head;
  entry_t          went;
  logic [PW-1:0]   wp, rp;
  logic [PW:0]     count;
  logic            push, pop, has_slot, take;

  function automatic logic [DW-1:0] sat(
    input logic signed [AW2-1:0] a
  );
    logic signed [AW2-1:0] s;
    s = a >>> FRACBITS;
    if (s > SMAX) return SMAX[DW-1:0];
    if (s < SMIN) return SMIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  assign beat = cnt[1:0];
  assign pass = cnt[3:2];

  // Lane l owns row LANES*pass+l; the accumulator restarts on beat 0.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      row[l]  = 2'(LANES * int'(pass) + l);
      prod[l] = $signed(mat[row[l]][beat]) * $signed(vin[beat]);
      sum[l]  = (beat == 2'd0 ? ZERO : acc[l]) + AW2'(prod[l]);
    end
  end

  assign head      = mem[rp];
  assign pop       = bus.res_valid && bus.res_ready;
  assign has_slot  = (count != (PW+1)'(OUT_DEPTH)) || pop;
  assign take      = (state == ACCEPT) && bus.vtx_valid && has_slot;
  assign push      = state == WRITE;

  assign went.vec    = stage;
  assign went.behind = stage[3][DW-1] || (stage[3] == '0);
  assign went.last   = last_r;

  assign bus.mvp_ready  = (state == IDLE) && !rst;
  assign bus.vtx_ready  = (state == ACCEPT) && has_slot;
  assign bus.finished   = state == DONE;
  assign bus.res_valid  = count != '0;
  assign bus.res        = bus.res_valid ? head.vec : '0;
  assign bus.res_behind = bus.res_valid && head.behind;
  assign bus.res_last   = bus.res_valid && head.last;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.mvp_valid) nxt = ACCEPT;
      ACCEPT:  if (take) nxt = COMPUTE;
      COMPUTE: if (cnt == 4'(BEATS - 1)) nxt = WRITE;
      WRITE:   nxt = last_r ? DRAIN : ACCEPT;
      DRAIN:   if (pop && head.last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mat    <= '0;
      vin    <= '0;
      stage  <= '0;
      last_r <= 1'b0;
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.mvp_valid) mat <= bus.mvp;
      if (take) begin
        vin    <= {ONE, bus.vtx[2], bus.vtx[1], bus.vtx[0]};
        last_r <= bus.vtx_last;
        cnt    <= '0;
      end
      if (state == COMPUTE) begin
        cnt <= cnt + 4'd1;
        for (int l = 0; l < LANES; l++) begin
          acc[l] <= sum[l];
          if (beat == 2'd3) stage[row[l]] <= sat(sum[l]);
        end
      end
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset: an empty count masks every output.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= went;
  end
endmodule

// File: tb/tb_vertex_transform_stream.sv
// Self-checking bench: vector table, backpressure/finish sequences,
// random stream vs arithmetic model, and mid-compute reset per lane count.
module tb_vertex_transform_stream;
  localparam int DW  = 24;
  localparam int ONE = 8192;

  typedef logic [3:0][3:0][DW-1:0] mat_t;
  typedef logic [3:0][DW-1:0]      vec_t;
  typedef struct { vec_t v; logic b; logic l; } ent_t;
  typedef struct {
    int m; int x; int y; int z;
    int ex; int ey; int ez; int ew; logic b;
  } rec_t;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  mat_t                 mvp_s       = '0;
  logic                 mvp_valid_s = 0;
  logic [2:0][DW-1:0]   vtx_s       = '0;
  logic                 vtx_last_s  = 0;
  logic                 vtx_valid_s = 0;
  logic                 rdy = 0, tog = 0, rnd = 0;
  logic                 res_ready_w;
  assign res_ready_w = tog ? rnd : rdy;

  vertex_transform_stream_if #(.DATAWIDTH(DW)) if0 ();
  vertex_transform_stream_if #(.DATAWIDTH(DW)) if1 ();
  vertex_transform_stream_if #(.DATAWIDTH(DW)) if2 ();

  assign if0.mvp = mvp_s;        assign if1.mvp = mvp_s;        assign if2.mvp = mvp_s;
  assign if0.mvp_valid = mvp_valid_s; assign if1.mvp_valid = mvp_valid_s; assign if2.mvp_valid = mvp_valid_s;
  assign if0.vtx = vtx_s;        assign if1.vtx = vtx_s;        assign if2.vtx = vtx_s;
  assign if0.vtx_last = vtx_last_s;   assign if1.vtx_last = vtx_last_s;   assign if2.vtx_last = vtx_last_s;
  assign if0.vtx_valid = vtx_valid_s; assign if1.vtx_valid = vtx_valid_s; assign if2.vtx_valid = vtx_valid_s;
  assign if0.res_ready = res_ready_w; assign if1.res_ready = res_ready_w; assign if2.res_ready = res_ready_w;

  logic mrdy_o [3], vrdy_o [3], val_o [3], beh_o [3], lst_o [3], fin_o [3];
  vec_t res_o [3];
  assign mrdy_o[0] = if0.mvp_ready;  assign mrdy_o[1] = if1.mvp_ready;  assign mrdy_o[2] = if2.mvp_ready;
  assign vrdy_o[0] = if0.vtx_ready;  assign vrdy_o[1] = if1.vtx_ready;  assign vrdy_o[2] = if2.vtx_ready;
  assign val_o[0]  = if0.res_valid;  assign val_o[1]  = if1.res_valid;  assign val_o[2]  = if2.res_valid;
  assign beh_o[0]  = if0.res_behind; assign beh_o[1]  = if1.res_behind; assign beh_o[2]  = if2.res_behind;
  assign lst_o[0]  = if0.res_last;   assign lst_o[1]  = if1.res_last;   assign lst_o[2]  = if2.res_last;
  assign fin_o[0]  = if0.finished;   assign fin_o[1]  = if1.finished;   assign fin_o[2]  = if2.finished;
  assign res_o[0]  = if0.res;        assign res_o[1]  = if1.res;        assign res_o[2]  = if2.res;

  vertex_transform_stream #(.DATAWIDTH(DW), .FRACBITS(13), .LANES(2), .OUT_DEPTH(4))
    dut2 (.clk(clk), .rst(rst), .bus(if0));
  vertex_transform_stream #(.DATAWIDTH(DW), .FRACBITS(13), .LANES(1), .OUT_DEPTH(4))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  vertex_transform_stream #(.DATAWIDTH(DW), .FRACBITS(13), .LANES(4), .OUT_DEPTH(4))
    dut4 (.clk(clk), .rst(rst), .bus(if2));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rnd = 1'($urandom_range(0, 1));
  end

  logic mon = 0;
  ent_t got_q [$];
  ent_t exp_q [$];
  int fin_cnt = 0, fin_cyc = -1, lastpop_cyc = -1;

  always @(negedge clk) begin
    if (mon && val_o[0] && res_ready_w) begin
      got_q.push_back('{res_o[0], beh_o[0], lst_o[0]});
      if (lst_o[0]) lastpop_cyc <= cyc;
    end
    if (mon && fin_o[0]) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc <= cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  function automatic ent_t model(mat_t m, int x, int y, int z, logic l);
    longint v [4];
    longint s;
    ent_t e;
    v[0] = x; v[1] = y; v[2] = z; v[3] = ONE;
    e.b = 0;
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += longint'($signed(m[r][k])) * v[k];
      s = s >>> 13;
      if (s > 64'sd8388607) s = 64'sd8388607;
      if (s < -64'sd8388608) s = -64'sd8388608;
      e.v[r] = 24'(s);
      if (r == 3) e.b = (s <= 0);
    end
    e.l = l;
    return e;
  endfunction

  function automatic int rnd24();
    logic signed [23:0] t;
    t = 24'($urandom);
    return int'(t) >>> $urandom_range(0, 12);
  endfunction

  mat_t cur_m;

  task automatic load(mat_t m);
    bit ok = 0;
    mvp_s = m;
    cur_m = m;
    mvp_valid_s = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mrdy_o[0]) begin ok = 1; break; end
    end
    if (!ok) check("mvp_load_timeout", 0, 1);
    @(posedge clk);
    #1 mvp_valid_s = 0;
  endtask

  task automatic send(int x, int y, int z, logic last, bit track);
    bit ok = 0;
    vtx_s = {24'(z), 24'(y), 24'(x)};
    vtx_last_s = last;
    vtx_valid_s = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vrdy_o[0]) begin ok = 1; break; end
    end
    if (!ok) check("vtx_accept_timeout", 0, 1);
    @(posedge clk);
    #1 vtx_valid_s = 0;
    if (track && ok) exp_q.push_back(model(cur_m, x, y, z, last));
  endtask

  task automatic wait_fin();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fin_o[0]) begin ok = 1; break; end
    end
    if (!ok) check("finished_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(string tag, int gb, int eb);
    check({tag, "_count"}, got_q.size() - gb, exp_q.size() - eb);
    for (int i = 0; i < exp_q.size() - eb && i < got_q.size() - gb; i++)
      check(tag, {got_q[gb+i].v, got_q[gb+i].b, got_q[gb+i].l},
                 {exp_q[eb+i].v, exp_q[eb+i].b, exp_q[eb+i].l});
  endtask

  mat_t mats [3];
  rec_t tbl [9];

  initial begin
    int n, gb, eb, f0;
    int pops [3];
    vec_t gv [3];
    vec_t e;
    bit fs [3];
    mat_t two_i, rm;

    mats[0] = '0; mats[1] = '0;
    for (int r = 0; r < 4; r++) begin
      mats[0][r][r] = 24'(8192);
      mats[1][r][r] = 24'(32768);
    end
    mats[1][0][3] = 24'(8192);
    mats[2] = mats[0];
    mats[2][3][3] = '0;
    mats[2][3][2] = 24'(-8192);

    tbl[0] = '{0, 8192, -16384, 4096, 8192, -16384, 4096, 8192, 0};
    tbl[1] = '{0, 100, -1, 0, 100, -1, 0, 8192, 0};
    tbl[2] = '{1, 4194304, 0, 0, 8388607, 0, 0, 32768, 0};
    tbl[3] = '{1, -4194304, 1000, -3, -8388608, 4000, -12, 32768, 0};
    tbl[4] = '{1, 1, 0, 0, 8196, 0, 0, 32768, 0};
    tbl[5] = '{2, 5, 6, 8192, 5, 6, 8192, -8192, 1};
    tbl[6] = '{2, -7, 0, 0, -7, 0, 0, 0, 1};
    tbl[7] = '{2, 0, 0, -4096, 0, 0, -4096, 4096, 0};
    tbl[8] = '{2, 0, 0, 1, 0, 0, 1, -1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      check("reset_outputs",
        {mrdy_o[g], vrdy_o[g], val_o[g], beh_o[g], lst_o[g], fin_o[g], res_o[g]}, '0);
    rst = 0;
    @(negedge clk);
    check("mvp_ready_after_reset", mrdy_o[0], 1);
    @(posedge clk);
    #1;

    // Vector table: one single-vertex mesh per record
    for (int i = 0; i < 9; i++) begin
      load(mats[tbl[i].m]);
      rdy = 0;
      send(tbl[i].x, tbl[i].y, tbl[i].z, 1, 0);
      n = 0;
      for (int c = 1; c <= 30; c++) begin
        @(posedge clk);
        #1;
        if (val_o[0]) begin n = c; break; end
      end
      check($sformatf("latency_%0d", i), n, 9);
      e[0] = 24'(tbl[i].ex); e[1] = 24'(tbl[i].ey);
      e[2] = 24'(tbl[i].ez); e[3] = 24'(tbl[i].ew);
      check($sformatf("vec_%0d", i), res_o[0], e);
      check($sformatf("flags_%0d", i), {beh_o[0], lst_o[0]}, {tbl[i].b, 1'b1});
      rdy = 1;
      wait_fin();
      rdy = 0;
    end

    // Backpressure: four fill the FIFO, the fifth must stall
    load(mats[1]);
    mon = 1;
    gb = got_q.size(); eb = exp_q.size();
    rdy = 0;
    for (int i = 0; i < 4; i++) send(rnd24(), rnd24(), rnd24(), 0, 1);
    vtx_s = '0;
    vtx_valid_s = 1;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vrdy_o[0]) n++;
    end
    check("t3_ready_held_low", n, 0);
    check("t3_head_held", {val_o[0], res_o[0]}, {1'b1, exp_q[eb].v});
    @(posedge clk);
    #1 rdy = 1;
    send(0, 0, 0, 0, 1);
    send(rnd24(), rnd24(), rnd24(), 1, 1);
    wait_fin();
    cmp_q("t3_order", gb, eb);

    // Last flag and finished pulse under toggling ready
    load(mats[0]);
    gb = got_q.size(); eb = exp_q.size();
    f0 = fin_cnt;
    tog = 1;
    for (int i = 0; i < 3; i++) send(rnd24(), rnd24(), rnd24(), i == 2, 1);
    wait_fin();
    tog = 0;
    check("t4_finish_pulses", fin_cnt - f0, 1);
    check("t4_finish_timing", fin_cyc, lastpop_cyc + 1);
    @(negedge clk);
    check("t4_mvp_ready_after", mrdy_o[0], 1);
    @(posedge clk);
    #1;
    cmp_q("t4_stream", gb, eb);

    // Random stream; a matrix offered mid-mesh must be ignored
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) rm[r][k] = 24'(rnd24());
    load(rm);
    gb = got_q.size(); eb = exp_q.size();
    mvp_s = ~rm;
    mvp_valid_s = 1;
    tog = 1;
    for (int i = 0; i < 20; i++) send(rnd24(), rnd24(), rnd24(), i == 19, 1);
    mvp_valid_s = 0;
    wait_fin();
    tog = 0;
    mon = 0;
    cmp_q("rand_stream", gb, eb);

    // Reset on compute beat 2 for LANES 1, 2 and 4
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    load(mats[0]);
    send(1000, 2000, 3000, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("t6_async_zero_%0d", g),
        {mrdy_o[g], vrdy_o[g], val_o[g], beh_o[g], lst_o[g], fin_o[g], res_o[g]}, '0);
    @(posedge clk);
    #1 rst = 0;
    two_i = '0;
    for (int r = 0; r < 4; r++) two_i[r][r] = 24'(16384);
    load(two_i);
    rdy = 1;
    send(3, -5, 7, 1, 0);
    for (int g = 0; g < 3; g++) begin pops[g] = 0; fs[g] = 0; gv[g] = '0; end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (val_o[g] && res_ready_w) begin
          if (pops[g] == 0) gv[g] = res_o[g];
          pops[g]++;
        end
        if (fin_o[g]) fs[g] = 1;
      end
    end
    e[0] = 24'(6); e[1] = 24'(-10); e[2] = 24'(14); e[3] = 24'(16384);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("t6_pops_%0d", g), pops[g], 1);
      check($sformatf("t6_vec_%0d", g), gv[g], e);
      check($sformatf("t6_finished_%0d", g), fs[g], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
